// File: rtl/alu_pkg.sv
// Shared function codes and operation classes for the 32-bit MIPS-style ALU.
// alu_mnemonic() is used by the optional ALU_PRINT_EN trace.
package alu_pkg;

  localparam logic [1:0] CLASS_ARITH = 2'b00;
  localparam logic [1:0] CLASS_LOGIC = 2'b01;
  localparam logic [1:0] CLASS_SHIFT = 2'b10;
  localparam logic [1:0] CLASS_CMP   = 2'b11;

  localparam logic [5:0] ALUFUNC_ADD = 6'b000000;
  localparam logic [5:0] ALUFUNC_SUB = 6'b000001;
  localparam logic [5:0] ALUFUNC_AND = 6'b011000;
  localparam logic [5:0] ALUFUNC_OR  = 6'b011110;
  localparam logic [5:0] ALUFUNC_XOR = 6'b010110;
  localparam logic [5:0] ALUFUNC_NOR = 6'b010001;
  localparam logic [5:0] ALUFUNC_A   = 6'b011010;
  localparam logic [5:0] ALUFUNC_SLL = 6'b100000;
  localparam logic [5:0] ALUFUNC_SRL = 6'b100001;
  localparam logic [5:0] ALUFUNC_SRA = 6'b100011;
  localparam logic [5:0] ALUFUNC_EQ  = 6'b110011;
  localparam logic [5:0] ALUFUNC_NEQ = 6'b110001;
  localparam logic [5:0] ALUFUNC_LT  = 6'b110101;
  localparam logic [5:0] ALUFUNC_LEZ = 6'b111101;
  localparam logic [5:0] ALUFUNC_GEZ = 6'b111001;
  localparam logic [5:0] ALUFUNC_GTZ = 6'b111111;

  // Four-character ASCII mnemonic, space padded.
  function automatic logic [31:0] alu_mnemonic(input logic [5:0] f);
    case (f)
      ALUFUNC_ADD: alu_mnemonic = "ADD ";
      ALUFUNC_SUB: alu_mnemonic = "SUB ";
      ALUFUNC_AND: alu_mnemonic = "AND ";
      ALUFUNC_OR:  alu_mnemonic = "OR  ";
      ALUFUNC_XOR: alu_mnemonic = "XOR ";
      ALUFUNC_NOR: alu_mnemonic = "NOR ";
      ALUFUNC_A:   alu_mnemonic = "A   ";
      ALUFUNC_SLL: alu_mnemonic = "SLL ";
      ALUFUNC_SRL: alu_mnemonic = "SRL ";
      ALUFUNC_SRA: alu_mnemonic = "SRA ";
      ALUFUNC_EQ:  alu_mnemonic = "EQ  ";
      ALUFUNC_NEQ: alu_mnemonic = "NEQ ";
      ALUFUNC_LT:  alu_mnemonic = "LT  ";
      ALUFUNC_LEZ: alu_mnemonic = "LEZ ";
      ALUFUNC_GEZ: alu_mnemonic = "GEZ ";
      ALUFUNC_GTZ: alu_mnemonic = "GTZ ";
      default:     alu_mnemonic = "??? ";
    endcase
  endfunction

endpackage

// File: rtl/alu_printer.sv
// Simulation-only operation trace, compiled only when ALU_PRINT_EN is defined.
// Prints operands, function and current result on each rising edge of pulse.
`ifdef ALU_PRINT_EN
module alu_printer
  import alu_pkg::*;
(
  input logic        pulse,
  input logic [31:0] a,
  input logic [31:0] b,
  input logic        signed_op,
  input logic [5:0]  alu_func,
  input logic [31:0] s
);

  always @(posedge pulse) begin
    $display("alu %s a=%b b=%b signed=%b func=%b s=%b",
             alu_mnemonic(alu_func), a, b, signed_op, alu_func, s);
  end

endmodule
`endif

// File: rtl/alu.sv
// Registered 32-bit MIPS-style ALU: arith, logic, shift and compare classes
// with one-cycle latency. Define ALU_PRINT_EN to add the alu_printer trace.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_op,
  input  logic [5:0]  alu_func,
  input  logic        pulse,
  output logic [31:0] s,
  output logic        zero,
  output logic        overflow,
  output logic        negative
);

  logic [1:0]  op_class;
  logic [31:0] arith_s, logic_s, shift_s, cmp_s, s_next;
  logic        arith_ovf, arith_neg;
  logic [31:0] b_op;
  logic [32:0] sum;
  logic [3:0]  truth;
  logic [4:0]  shamt;
  logic        a_neg, a_is_zero, cond;

  assign op_class = alu_func[5:4];

  // SUB is a + ~b + 1; bit 32 of sum is carry-out, and borrow is its inverse.
  always_comb begin
    b_op    = alu_func[0] ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_op} + {32'b0, alu_func[0]};
    arith_s = sum[31:0];
    if (signed_op) begin
      arith_ovf = (a[31] == b_op[31]) && (sum[31] != a[31]);
      arith_neg = sum[31] ^ arith_ovf;
    end else if (alu_func[0]) begin
      arith_ovf = ~sum[32];
      arith_neg = ~sum[32];
    end else begin
      arith_ovf = sum[32];
      arith_neg = 1'b0;
    end
  end

  // The low nibble of alu_func is a truth table indexed by {b[i], a[i]}.
  always_comb begin
    truth   = alu_func[3:0];
    logic_s = '0;
    for (int i = 0; i < 32; i++) begin
      logic_s[i] = truth[{b[i], a[i]}];
    end
  end

  always_comb begin
    shamt = a[4:0];
    case (alu_func[1:0])
      2'b01:   shift_s = b >> shamt;
      2'b11:   shift_s = $signed(b) >>> shamt;
      default: shift_s = b << shamt;
    endcase
  end

  // Zero-compares see a as unsigned when signed_op is clear, so a_neg is 0.
  always_comb begin
    a_neg     = signed_op & a[31];
    a_is_zero = (a == 32'd0);
    case (alu_func)
      ALUFUNC_EQ:  cond = (a == b);
      ALUFUNC_NEQ: cond = (a != b);
      ALUFUNC_LT:  cond = signed_op ? ($signed(a) < $signed(b)) : (a < b);
      ALUFUNC_LEZ: cond = a_neg | a_is_zero;
      ALUFUNC_GEZ: cond = ~a_neg;
      ALUFUNC_GTZ: cond = ~a_neg & ~a_is_zero;
      default:     cond = 1'b0;
    endcase
    cmp_s = {31'b0, cond};
  end

  always_comb begin
    case (op_class)
      CLASS_ARITH: s_next = arith_s;
      CLASS_LOGIC: s_next = logic_s;
      CLASS_SHIFT: s_next = shift_s;
      default:     s_next = cmp_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
    end else begin
      s        <= s_next;
      zero     <= (s_next == 32'd0);
      overflow <= (op_class == CLASS_ARITH) & arith_ovf;
      negative <= (op_class == CLASS_ARITH) & arith_neg;
    end
  end

`ifdef ALU_PRINT_EN
  alu_printer u_printer (
    .pulse     (pulse),
    .a         (a),
    .b         (b),
    .signed_op (signed_op),
    .alu_func  (alu_func),
    .s         (s)
  );
`else
  logic unused_pulse;
  assign unused_pulse = pulse;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset behaviour and a
// randomized run against an independent integer model, via an expected queue.
module tb_alu;
  import alu_pkg::*;

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] va;
    logic [31:0] vb;
    logic        sg;
    logic [34:0] ex;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        signed_op = 1'b0;
  logic [5:0]  alu_func = '0;
  logic        pulse = 1'b0;
  logic [31:0] s;
  logic        zero, overflow, negative;

  logic [34:0] exp_q[$];
  int pass_cnt = 0;
  int check_cnt = 0;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .signed_op (signed_op),
    .alu_func  (alu_func),
    .pulse     (pulse),
    .s         (s),
    .zero      (zero),
    .overflow  (overflow),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  // Expected {s, zero, overflow, negative} from exact 64-bit integer arithmetic.
  function automatic logic [34:0] model(input logic [5:0] f, input logic [31:0] ma,
                                        input logic [31:0] mb, input logic sg);
    longint ea, eb, r;
    logic [31:0] rs;
    logic ov, ng;
    ea = sg ? longint'($signed(ma)) : longint'({32'b0, ma});
    eb = sg ? longint'($signed(mb)) : longint'({32'b0, mb});
    rs = '0; ov = 1'b0; ng = 1'b0; r = 0;
    case (f)
      ALUFUNC_ADD, ALUFUNC_SUB: begin
        r  = (f == ALUFUNC_ADD) ? ea + eb : ea - eb;
        rs = r[31:0];
        if (sg) begin
          ov = (r != longint'($signed(rs)));
          ng = (r < 0);
        end else if (f == ALUFUNC_ADD) begin
          ov = r[32];
        end else begin
          ov = (r < 0);
          ng = (r < 0);
        end
      end
      ALUFUNC_AND: rs = ma & mb;
      ALUFUNC_OR:  rs = ma | mb;
      ALUFUNC_XOR: rs = ma ^ mb;
      ALUFUNC_NOR: rs = ~(ma | mb);
      ALUFUNC_A:   rs = ma;
      ALUFUNC_SLL, 6'b100010: rs = mb << ma[4:0];
      ALUFUNC_SRL: rs = mb >> ma[4:0];
      ALUFUNC_SRA: rs = 32'($signed(mb) >>> ma[4:0]);
      ALUFUNC_EQ:  rs = {31'b0, ma == mb};
      ALUFUNC_NEQ: rs = {31'b0, ma != mb};
      ALUFUNC_LT:  rs = {31'b0, ea < eb};
      ALUFUNC_LEZ: rs = {31'b0, ea <= 0};
      ALUFUNC_GEZ: rs = {31'b0, ea >= 0};
      ALUFUNC_GTZ: rs = {31'b0, ea > 0};
      default:     rs = '0;
    endcase
    return {rs, rs == 32'd0, ov, ng};
  endfunction

  // Drive one operation after a falling edge, queue its expectation, and
  // return just after the capturing rising edge.
  task automatic drive(input logic [5:0] f, input logic [31:0] va, input logic [31:0] vb,
                       input logic sg, input logic [34:0] ex);
    @(negedge clk);
    alu_func  = f;
    a         = va;
    b         = vb;
    signed_op = sg;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [34:0] got;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {s, zero, overflow, negative};
    check_cnt++;
    if (got !== 35'd0) $display("FAIL reset_hold: got %h expected %h", got, 35'd0);
    else pass_cnt++;
    @(negedge clk);
    alu_func = ALUFUNC_ADD; a = 32'd1; b = 32'd2; signed_op = 1'b0;
    rst_n = 1'b1;
    #1;
    got = {s, zero, overflow, negative};
    check_cnt++;
    if (got !== 35'd0) $display("FAIL release_before_edge: got %h expected %h", got, 35'd0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    got = {s, zero, overflow, negative};
    check_cnt++;
    if (got !== {32'd3, 3'b000}) $display("FAIL release_latency: got %h expected %h", got, {32'd3, 3'b000});
    else pass_cnt++;
  endtask

  task automatic test_logic;
    vec_t v[9];
    logic [34:0] got, want;
    v = '{
      '{ALUFUNC_AND, 32'd15, 32'hFFFFFFDD, 1'b1, {32'h0000000D, 3'b000}},
      '{ALUFUNC_OR,  32'd15, 32'hFFFFFFDD, 1'b1, {32'hFFFFFFDF, 3'b000}},
      '{ALUFUNC_XOR, 32'd15, 32'hFFFFFFDD, 1'b1, {32'hFFFFFFD2, 3'b000}},
      '{ALUFUNC_NOR, 32'd15, 32'hFFFFFFDD, 1'b1, {32'h00000020, 3'b000}},
      '{ALUFUNC_A,   32'd15, 32'hFFFFFFDD, 1'b1, {32'h0000000F, 3'b000}},
      '{6'b010111,   32'd15, 32'hFFFFFFDD, 1'b1, {32'hFFFFFFF2, 3'b000}},
      '{6'b010000,   32'd15, 32'hFFFFFFDD, 1'b1, {32'h00000000, 3'b100}},
      '{6'b011111,   32'd15, 32'hFFFFFFDD, 1'b0, {32'hFFFFFFFF, 3'b000}},
      '{6'b011100,   32'd15, 32'hFFFFFFDD, 1'b0, {32'hFFFFFFDD, 3'b000}}
    };
    for (int i = 0; i < 9; i++) begin
      drive(v[i].f, v[i].va, v[i].vb, v[i].sg, v[i].ex);
      got  = {s, zero, overflow, negative};
      want = exp_q.pop_front();
      check_cnt++;
      if (got !== want) $display("FAIL logic[%0d]: got s=%h zon=%b expected s=%h zon=%b",
                                 i, got[34:3], got[2:0], want[34:3], want[2:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_shift;
    vec_t v[7];
    logic [34:0] got, want;
    v = '{
      '{ALUFUNC_SLL, 32'd22, 32'hFFFFFFDD, 1'b1, {32'hF7400000, 3'b000}},
      '{ALUFUNC_SRL, 32'd3,  32'hFFFFFFDD, 1'b1, {32'h1FFFFFFB, 3'b000}},
      '{ALUFUNC_SRA, 32'd3,  32'hFFFFFFDD, 1'b1, {32'hFFFFFFFB, 3'b000}},
      '{6'b100010,   32'd4,  32'h0000000F, 1'b0, {32'h000000F0, 3'b000}},
      '{ALUFUNC_SLL, 32'hFFFFFFE0, 32'h12345678, 1'b0, {32'h12345678, 3'b000}},
      '{ALUFUNC_SRA, 32'd31, 32'h80000000, 1'b0, {32'hFFFFFFFF, 3'b000}},
      '{ALUFUNC_SRL, 32'd31, 32'h7FFFFFFF, 1'b0, {32'h00000000, 3'b100}}
    };
    for (int i = 0; i < 7; i++) begin
      drive(v[i].f, v[i].va, v[i].vb, v[i].sg, v[i].ex);
      got  = {s, zero, overflow, negative};
      want = exp_q.pop_front();
      check_cnt++;
      if (got !== want) $display("FAIL shift[%0d]: got s=%h zon=%b expected s=%h zon=%b",
                                 i, got[34:3], got[2:0], want[34:3], want[2:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_arith;
    vec_t v[6];
    logic [34:0] got, want;
    v = '{
      '{ALUFUNC_SUB, 32'hFFFFFFFF, 32'd1, 1'b0, {32'hFFFFFFFE, 3'b000}},
      '{ALUFUNC_ADD, 32'hFFFFFFFF, 32'd1, 1'b0, {32'h00000000, 3'b110}},
      '{ALUFUNC_ADD, 32'h7FFFFFFF, 32'd1, 1'b1, {32'h80000000, 3'b010}},
      '{ALUFUNC_SUB, 32'd0,        32'd1, 1'b1, {32'hFFFFFFFF, 3'b001}},
      '{ALUFUNC_SUB, 32'd0,        32'd1, 1'b0, {32'hFFFFFFFF, 3'b011}},
      '{ALUFUNC_SUB, 32'h80000000, 32'd1, 1'b1, {32'h7FFFFFFF, 3'b011}}
    };
    for (int i = 0; i < 6; i++) begin
      drive(v[i].f, v[i].va, v[i].vb, v[i].sg, v[i].ex);
      got  = {s, zero, overflow, negative};
      want = exp_q.pop_front();
      check_cnt++;
      if (got !== want) $display("FAIL arith[%0d]: got s=%h zon=%b expected s=%h zon=%b",
                                 i, got[34:3], got[2:0], want[34:3], want[2:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_compare;
    vec_t v[13];
    logic [34:0] got, want;
    v = '{
      '{ALUFUNC_EQ,  32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 3'b100}},
      '{ALUFUNC_NEQ, 32'hFFFFFFFF, 32'd1, 1'b0, {32'd1, 3'b000}},
      '{ALUFUNC_LT,  32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 3'b100}},
      '{ALUFUNC_LEZ, 32'hFFFFFFFF, 32'd1, 1'b1, {32'd1, 3'b000}},
      '{ALUFUNC_GEZ, 32'hFFFFFFFF, 32'd1, 1'b1, {32'd0, 3'b100}},
      '{ALUFUNC_GTZ, 32'hFFFFFFFF, 32'd1, 1'b1, {32'd0, 3'b100}},
      '{ALUFUNC_LT,  32'hFFFFFFFF, 32'd1, 1'b1, {32'd1, 3'b000}},
      '{ALUFUNC_LEZ, 32'd0,        32'd0, 1'b0, {32'd1, 3'b000}},
      '{ALUFUNC_GEZ, 32'hFFFFFFFF, 32'd0, 1'b0, {32'd1, 3'b000}},
      '{ALUFUNC_GTZ, 32'hFFFFFFFF, 32'd0, 1'b0, {32'd1, 3'b000}},
      '{ALUFUNC_GTZ, 32'd0,        32'd0, 1'b1, {32'd0, 3'b100}},
      '{ALUFUNC_EQ,  32'h12345678, 32'h12345678, 1'b1, {32'd1, 3'b000}},
      '{6'b110000,   32'd5,        32'd5, 1'b1, {32'd0, 3'b100}}
    };
    for (int i = 0; i < 13; i++) begin
      drive(v[i].f, v[i].va, v[i].vb, v[i].sg, v[i].ex);
      got  = {s, zero, overflow, negative};
      want = exp_q.pop_front();
      check_cnt++;
      if (got !== want) $display("FAIL compare[%0d]: got s=%h zon=%b expected s=%h zon=%b",
                                 i, got[34:3], got[2:0], want[34:3], want[2:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream;
    logic [34:0] got, want;
    drive(ALUFUNC_ADD, 32'd5, 32'd6, 1'b0, {32'd11, 3'b000});
    got  = {s, zero, overflow, negative};
    want = exp_q.pop_front();
    check_cnt++;
    if (got !== want) $display("FAIL pre_reset: got %h expected %h", got, want);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    got = {s, zero, overflow, negative};
    check_cnt++;
    if (got !== 35'd0) $display("FAIL async_clear: got %h expected %h", got, 35'd0);
    else pass_cnt++;
    @(negedge clk);
    alu_func = ALUFUNC_OR; a = 32'h0000F000; b = 32'h0000000F; signed_op = 1'b0;
    @(posedge clk);
    #1;
    got = {s, zero, overflow, negative};
    check_cnt++;
    if (got !== 35'd0) $display("FAIL inflight_discard: got %h expected %h", got, 35'd0);
    else pass_cnt++;
    rst_n = 1'b1;
    drive(ALUFUNC_XOR, 32'hA5A5A5A5, 32'hFFFF0000, 1'b0, {32'h5A5AA5A5, 3'b000});
    got  = {s, zero, overflow, negative};
    want = exp_q.pop_front();
    check_cnt++;
    if (got !== want) $display("FAIL post_reset: got %h expected %h", got, want);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [5:0]  codes [17];
    logic [31:0] specials [4];
    logic [5:0]  f;
    logic [31:0] va, vb;
    logic        sg;
    logic [34:0] got, want;
    codes = '{ALUFUNC_ADD, ALUFUNC_SUB, ALUFUNC_AND, ALUFUNC_OR, ALUFUNC_XOR, ALUFUNC_NOR,
              ALUFUNC_A, ALUFUNC_SLL, 6'b100010, ALUFUNC_SRL, ALUFUNC_SRA, ALUFUNC_EQ,
              ALUFUNC_NEQ, ALUFUNC_LT, ALUFUNC_LEZ, ALUFUNC_GEZ, ALUFUNC_GTZ};
    specials = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 120; i++) begin
      f  = codes[$urandom_range(0, 16)];
      va = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
      vb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
      if ($urandom_range(0, 4) == 0) vb = va;
      sg = 1'($urandom_range(0, 1));
      drive(f, va, vb, sg, model(f, va, vb, sg));
      got  = {s, zero, overflow, negative};
      want = exp_q.pop_front();
      check_cnt++;
      if (got !== want) $display("FAIL random[%0d] f=%b a=%h b=%h sg=%b: got s=%h zon=%b expected s=%h zon=%b",
                                 i, f, va, vb, sg, got[34:3], got[2:0], want[34:3], want[2:0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_shift();
    test_arith();
    test_compare();
    test_reset_midstream();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
